// File: rtl/pipelined_right_barrel_shifter_if.sv
// rtl/pipelined_right_barrel_shifter_if.sv - operand/result handshake bundle for the right barrel shifter
interface pipelined_right_barrel_shifter_if #(
   parameter int N   = 8,
   parameter int SHW = $clog2(N)
);
   logic           in_valid;
   logic           in_ready;
   logic [N-1:0]   data_in;
   logic [SHW-1:0] shamt;
   logic           arith;
   logic           out_valid;
   logic           out_ready;
   logic [N-1:0]   data_out;
   logic           sticky;

   modport master (
      output in_valid, data_in, shamt, arith, out_ready,
      input  in_ready, out_valid, data_out, sticky
   );

   modport slave (
      input  in_valid, data_in, shamt, arith, out_ready,
      output in_ready, out_valid, data_out, sticky
   );
endinterface

// File: rtl/pipelined_right_barrel_shifter.sv
// rtl/pipelined_right_barrel_shifter.sv - pipelined logical/arithmetic right shifter with sticky bit
// One register per power-of-two shift distance, largest distance first; valid/ready on both ends.
module pipelined_right_barrel_shifter #(
   parameter int N   = 8,
   parameter int SHW = $clog2(N)
) (
   input  logic                              clk,
   input  logic                              rst,
   pipelined_right_barrel_shifter_if.slave   bus
);

   logic [SHW-1:0] w_valid;
   logic [SHW-1:0] w_adv;

   // A stage may load when it is empty or its contents move on this cycle.
   always_comb begin
      w_adv = '0;
      w_adv[SHW-1] = bus.out_ready | ~w_valid[SHW-1];
      for (int k = SHW - 2; k >= 0; k--) begin
         w_adv[k] = ~w_valid[k] | w_adv[k+1];
      end
   end

   for (genvar k = 0; k < SHW; k++) begin : g_stage
      localparam int DIST = 1 << (SHW - 1 - k);

      logic             w_src_valid;
      logic [N-1:0]     w_src_data;
      logic [SHW-k-1:0] w_src_shamt;
      logic             w_src_arith;
      logic             w_src_sticky;
      logic             w_take;
      logic             w_fill;
      logic             w_lost;
      logic [N-1:0]     w_shifted;

      logic             r_valid;
      logic [N-1:0]     r_data;
      logic             r_sticky;

      if (k == 0) begin : g_src
         assign w_src_valid  = bus.in_valid;
         assign w_src_data   = bus.data_in;
         assign w_src_shamt  = bus.shamt;
         assign w_src_arith  = bus.arith;
         assign w_src_sticky = 1'b0;
      end else begin : g_src
         assign w_src_valid  = g_stage[k-1].r_valid;
         assign w_src_data   = g_stage[k-1].r_data;
         assign w_src_shamt  = g_stage[k-1].g_ctl.r_shamt;
         assign w_src_arith  = g_stage[k-1].g_ctl.r_arith;
         assign w_src_sticky = g_stage[k-1].r_sticky;
      end

      // The MSB of the remaining shift amount selects this stage's distance.
      assign w_take    = w_src_shamt[SHW-k-1];
      assign w_fill    = w_src_arith & w_src_data[N-1];
      assign w_shifted = w_take ? {{DIST{w_fill}}, w_src_data[N-1:DIST]} : w_src_data;
      assign w_lost    = w_take & (|w_src_data[DIST-1:0]);

      always_ff @(posedge clk) begin
         if (rst) begin
            r_valid  <= 1'b0;
            r_data   <= '0;
            r_sticky <= 1'b0;
         end else if (w_adv[k]) begin
            r_valid <= w_src_valid;
            if (w_src_valid) begin
               r_data   <= w_shifted;
               r_sticky <= w_src_sticky | w_lost;
            end
         end
      end

      // Only the still-unconsumed shift bits travel forward; the last stage needs none.
      if (k < SHW - 1) begin : g_ctl
         logic [SHW-k-2:0] r_shamt;
         logic             r_arith;

         always_ff @(posedge clk) begin
            if (rst) begin
               r_shamt <= '0;
               r_arith <= 1'b0;
            end else if (w_adv[k] && w_src_valid) begin
               r_shamt <= w_src_shamt[SHW-k-2:0];
               r_arith <= w_src_arith;
            end
         end
      end

      assign w_valid[k] = r_valid;
   end

   assign bus.in_ready  = w_adv[0];
   assign bus.out_valid = g_stage[SHW-1].r_valid;
   assign bus.data_out  = g_stage[SHW-1].r_data;
   assign bus.sticky    = g_stage[SHW-1].r_sticky;

endmodule

// File: tb/tb_pipelined_right_barrel_shifter.sv
// tb/tb_pipelined_right_barrel_shifter.sv - scoreboard bench for the pipelined right barrel shifter
module tb_pipelined_right_barrel_shifter;

   localparam int N   = 8;
   localparam int SHW = 3;

   typedef struct {
      logic [N-1:0] data;
      logic         st;
      int           acc_edge;
      bit           lat_chk;
   } exp_t;

   logic clk;
   logic rst;
   int   cyc;
   int   errors;
   int   checks;
   exp_t q[$];

   pipelined_right_barrel_shifter_if #(.N(N), .SHW(SHW)) bus ();

   pipelined_right_barrel_shifter #(.N(N), .SHW(SHW)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   initial cyc = 0;
   always @(posedge clk) cyc++;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   function automatic void model(input logic [N-1:0] d, input int s, input logic a,
                                 output logic [N-1:0] r, output logic st);
      logic signed [N-1:0] sd;
      int unsigned mask;
      sd   = d;
      mask = (32'd1 << s) - 1;
      if (a) r = sd >>> s;
      else   r = d >> s;
      st = ((32'(d) & mask) != 0);
   endfunction

   task automatic push(input logic [N-1:0] d, input logic st, input bit lat);
      exp_t e;
      e.data = d;
      e.st = st;
      e.acc_edge = cyc + 1;
      e.lat_chk = lat;
      q.push_back(e);
   endtask

   // Drive one cycle at the falling edge and report whether the coming edge accepts.
   task automatic step(input logic v, input logic [N-1:0] d, input logic [SHW-1:0] s,
                       input logic a, input logic ordy, input logic r, output logic acc);
      @(negedge clk);
      rst           = r;
      bus.in_valid  = v;
      bus.data_in   = d;
      bus.shamt     = s;
      bus.arith     = a;
      bus.out_ready = ordy;
      #4;
      acc = v && bus.in_ready && !r;
   endtask

   task automatic drain(input int max_cycles);
      logic acc;
      for (int i = 0; i < max_cycles && q.size() > 0; i++) begin
         step(1'b0, '0, '0, 1'b0, 1'b1, 1'b0, acc);
      end
      check("drain_empty", q.size(), 0);
   endtask

   // Monitor: pops the scoreboard on every output transfer, also checks hold stability.
   initial begin
      exp_t e;
      logic         held;
      logic [N-1:0] hd;
      logic         hs;
      held = 1'b0;
      hd = '0;
      hs = 1'b0;
      forever begin
         @(negedge clk);
         #3;
         if (rst) begin
            held = 1'b0;
            continue;
         end
         if (held && bus.out_valid) begin
            check("hold_data", bus.data_out, hd);
            check("hold_sticky", bus.sticky, hs);
         end
         if (bus.out_valid && bus.out_ready) begin
            if (q.size() == 0) begin
               checks++;
               errors++;
               $display("FAIL unexpected_output: got %0h expected none", bus.data_out);
            end else begin
               e = q.pop_front();
               check("out_data", bus.data_out, e.data);
               check("out_sticky", bus.sticky, e.st);
               if (e.lat_chk) check("latency", (cyc + 1) - e.acc_edge, SHW);
            end
            held = 1'b0;
         end else if (bus.out_valid) begin
            held = 1'b1;
            hd = bus.data_out;
            hs = bus.sticky;
         end else begin
            held = 1'b0;
         end
      end
   end

   logic [N-1:0]   dir_d   [6] = '{8'h96, 8'h96, 8'h80, 8'h80, 8'h96, 8'h40};
   logic [SHW-1:0] dir_s   [6] = '{3'd3, 3'd3, 3'd7, 3'd7, 3'd0, 3'd6};
   logic           dir_a   [6] = '{1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0};
   logic [N-1:0]   dir_exp [6] = '{8'h12, 8'hF2, 8'hFF, 8'h01, 8'h96, 8'h01};
   logic           dir_st  [6] = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0};

   initial begin
      logic acc;
      logic have;
      logic [N-1:0] rd;
      logic [N-1:0] rexp;
      logic [SHW-1:0] rs;
      logic ra;
      logic rst_exp;
      int idx;
      int sent;
      int cnt;

      errors = 0;
      checks = 0;
      rst = 1'b1;
      bus.in_valid = 1'b0;
      bus.data_in = '0;
      bus.shamt = '0;
      bus.arith = 1'b0;
      bus.out_ready = 1'b0;

      step(1'b1, 8'h55, 3'd1, 1'b0, 1'b1, 1'b1, acc);
      step(1'b0, '0, '0, 1'b0, 1'b1, 1'b1, acc);
      step(1'b0, '0, '0, 1'b0, 1'b1, 1'b0, acc);
      check("rst_out_valid", bus.out_valid, 0);
      check("rst_data_out", bus.data_out, 0);
      check("rst_sticky", bus.sticky, 0);
      check("rst_in_ready", bus.in_ready, 1);

      // Directed single items with exact latency
      for (int i = 0; i < 6; i++) begin
         step(1'b1, dir_d[i], dir_s[i], dir_a[i], 1'b1, 1'b0, acc);
         check("dir_accept", acc, 1);
         if (acc) push(dir_exp[i], dir_st[i], 1'b1);
         drain(20);
      end

      // Back-to-back stream with a backpressure window
      idx = 0;
      for (int c = 0; c < 60 && (idx < 8 || q.size() > 0); c++) begin
         step(idx < 8, 8'(idx + 1), 3'd0, 1'b0, !(c >= 2 && c <= 7), 1'b0, acc);
         if (c == 3) begin
            check("stall_in_ready_low", bus.in_ready, 0);
            check("stall_items_held", idx, SHW);
         end
         if (c == 8) check("stall_in_ready_back", bus.in_ready, 1);
         if (acc) begin
            push(8'(idx + 1), 1'b0, 1'b0);
            idx++;
         end
      end
      check("stream_sent", idx, 8);
      check("stream_empty", q.size(), 0);

      // Full throughput with out_ready held high
      cnt = 0;
      for (int c = 0; c < 16; c++) begin
         rd = 8'($urandom);
         rs = 3'($urandom_range(0, 7));
         ra = 1'($urandom_range(0, 1));
         step(1'b1, rd, rs, ra, 1'b1, 1'b0, acc);
         if (acc) begin
            model(rd, int'(rs), ra, rexp, rst_exp);
            push(rexp, rst_exp, 1'b0);
            cnt++;
         end
      end
      check("throughput", cnt, 16);
      drain(20);

      // Randomized bubbles and backpressure
      have = 1'b0;
      sent = 0;
      rd = '0;
      rs = '0;
      ra = 1'b0;
      for (int c = 0; c < 20000 && sent < 1000; c++) begin
         if (!have) begin
            rd = 8'($urandom);
            rs = 3'($urandom_range(0, 7));
            ra = 1'($urandom_range(0, 1));
            have = 1'b1;
         end
         step($urandom_range(0, 9) < 7, rd, rs, ra, $urandom_range(0, 9) < 6, 1'b0, acc);
         if (acc) begin
            model(rd, int'(rs), ra, rexp, rst_exp);
            push(rexp, rst_exp, 1'b0);
            sent++;
            have = 1'b0;
         end
      end
      check("random_sent", sent, 1000);
      drain(50);

      // Reset with items in flight
      for (int i = 0; i < SHW; i++) begin
         step(1'b1, 8'(8'hA0 + i), 3'd1, 1'b0, 1'b0, 1'b0, acc);
         check("flight_accept", acc, 1);
      end
      step(1'b1, 8'hC3, 3'd2, 1'b1, 1'b0, 1'b1, acc);
      check("rst_no_accept", acc, 0);
      q.delete();
      step(1'b0, '0, '0, 1'b0, 1'b1, 1'b0, acc);
      check("midrst_out_valid", bus.out_valid, 0);
      check("midrst_data_out", bus.data_out, 0);
      check("midrst_sticky", bus.sticky, 0);
      check("midrst_in_ready", bus.in_ready, 1);
      for (int i = 0; i < 10; i++) step(1'b0, '0, '0, 1'b0, 1'b1, 1'b0, acc);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
